// File: rtl/cache_mem_arbiter.sv
// Shares one multi-cycle main memory between the I-cache and D-cache miss handlers:
// 8-word block fills for either cache and single-word write-through stores for the D-cache.
module cache_mem_arbiter #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_req,
    input  logic [ADDR_W-1:0] icache_addr,
    output logic              icache_grant,
    output logic              icache_data_valid,
    output logic              icache_done,
    input  logic              dcache_req,
    input  logic              dcache_we,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [DATA_W-1:0] dcache_wdata,
    output logic              dcache_grant,
    output logic              dcache_data_valid,
    output logic              dcache_done,
    output logic [DATA_W-1:0] fill_data,
    output logic [2:0]        fill_word_idx,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid
);

    typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE_D} state_t;

    localparam logic              GRANT_I     = 1'b0;
    localparam logic              GRANT_D     = 1'b1;
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);
    localparam logic [3:0]        ISSUE_TOTAL = 4'(WORDS_PER_BLOCK);
    localparam logic [2:0]        LAST_RET    = 3'(WORDS_PER_BLOCK - 1);

    state_t            state_q, state_d;
    logic [3:0]        issue_cnt_q, issue_cnt_d;
    logic [2:0]        ret_cnt_q, ret_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              in_fill;

    assign in_fill = (state_q == FILL_I) || (state_q == FILL_D);

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values computed by the combinational block below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            issue_cnt_q  <= '0;
            ret_cnt_q    <= '0;
            last_grant_q <= GRANT_I;
            base_q       <= '0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
            last_grant_q <= last_grant_d;
            base_q       <= base_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d           = state_q;
        issue_cnt_d       = issue_cnt_q;
        ret_cnt_d         = ret_cnt_q;
        last_grant_d      = last_grant_q;
        base_d            = base_q;
        icache_grant      = 1'b0;
        icache_data_valid = 1'b0;
        icache_done       = 1'b0;
        dcache_grant      = 1'b0;
        dcache_data_valid = 1'b0;
        dcache_done       = 1'b0;
        fill_data         = '0;
        fill_word_idx     = '0;
        mem_enable        = 1'b0;
        mem_wr            = 1'b0;
        mem_addr          = '0;
        mem_wdata         = '0;

        case (state_q)
            IDLE: begin
                issue_cnt_d = '0;
                ret_cnt_d   = '0;
                // A tie goes to whichever side was not served last.
                if (icache_req && (!dcache_req || last_grant_q == GRANT_D)) begin
                    state_d      = FILL_I;
                    last_grant_d = GRANT_I;
                    base_d       = icache_addr & ~OFFSET_MASK;
                end else if (dcache_req) begin
                    state_d      = dcache_we ? WRITE_D : FILL_D;
                    last_grant_d = GRANT_D;
                    base_d       = dcache_addr & ~OFFSET_MASK;
                end
            end

            FILL_I, FILL_D: begin
                icache_grant = (state_q == FILL_I);
                dcache_grant = (state_q == FILL_D);
                if (issue_cnt_q < ISSUE_TOTAL) begin
                    mem_enable  = 1'b1;
                    mem_addr    = base_q + ADDR_W'({issue_cnt_q, 1'b0});
                    issue_cnt_d = issue_cnt_q + 4'd1;
                end
                if (mem_data_valid) begin
                    fill_data         = mem_rdata;
                    fill_word_idx     = ret_cnt_q;
                    icache_data_valid = (state_q == FILL_I);
                    dcache_data_valid = (state_q == FILL_D);
                    ret_cnt_d         = ret_cnt_q + 3'd1;
                    if (ret_cnt_q == LAST_RET) begin
                        icache_done = (state_q == FILL_I);
                        dcache_done = (state_q == FILL_D);
                        state_d     = IDLE;
                        issue_cnt_d = '0;
                        ret_cnt_d   = '0;
                    end
                end
            end

            WRITE_D: begin
                dcache_grant = 1'b1;
                mem_enable   = 1'b1;
                mem_wr       = 1'b1;
                mem_addr     = dcache_addr;
                mem_wdata    = dcache_wdata;
                dcache_done  = 1'b1;
                state_d      = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // A read cannot come back sooner than MEM_LATENCY cycles after it was issued.
    assert property (@(posedge clk) disable iff (rst)
        (in_fill && mem_data_valid) |->
        (int'(issue_cnt_q) >= ((int'(ret_cnt_q) + MEM_LATENCY > WORDS_PER_BLOCK) ?
                               WORDS_PER_BLOCK : int'(ret_cnt_q) + MEM_LATENCY)));

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single multi-cycle main memory between the I-cache and D-cache miss handlers.
- Sequences full-block fills (8 words) for either cache, and single-word write-through stores for the D-cache.
- Sits between both cache controllers and main memory. The pipeline stall signals (cstall and the I-side equivalent) are derived from the grant/done outputs by the caches.

Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- WORDS_PER_BLOCK, 8, words per cache block (block = 16 bytes)
- MEM_LATENCY, 4, cycles from mem_enable to mem_data_valid for a read

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- icache_req  in  1  I-cache fill request, level; held until done
- icache_addr  in  ADDR_W  miss address (any byte in block)
- icache_grant  out  1  I fill in progress
- icache_data_valid  out  1  fill_data valid for I-cache this cycle
- icache_done  out  1  one-cycle pulse: I fill complete
- dcache_req  in  1  D-cache request, level; held until done
- dcache_we  in  1  1 = single-word write, 0 = block fill
- dcache_addr  in  ADDR_W  miss/store address
- dcache_wdata  in  DATA_W  store data
- dcache_grant  out  1  D transaction in progress
- dcache_data_valid  out  1  fill_data valid for D-cache this cycle
- dcache_done  out  1  one-cycle pulse: D transaction complete
- fill_data  out  DATA_W  returned word (shared by both caches)
- fill_word_idx  out  3  block offset (0..7) of fill_data
- mem_enable  out  1  memory access this cycle
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_data_valid  in  1  mem_rdata valid

Behaviour:
- States: IDLE, FILL_I, FILL_D, WRITE_D.
- Reset (async): state=IDLE, issue_cnt=0, ret_cnt=0, last_grant=I. All outputs 0.
- IDLE arbitration, sampled at the clock edge:
  - Only one requester: grant it.
  - Both requesting: grant the one not equal to last_grant (round-robin). After reset a tie goes to D.
  - Neither requesting: stay in IDLE.
- Grant targets: D with dcache_we=1 goes to WRITE_D; D with we=0 goes to FILL_D; I goes to FILL_I. last_grant is updated on each grant.
- Grant timing: grant rises the cycle after the request is sampled and stays high through the done cycle.
- FILL (I or D):
  - base = addr & ~(2*WORDS_PER_BLOCK-1), i.e. addr[15:4]<<4, latched at grant.
  - Issue phase: cycles 0..7 of the state drive mem_enable=1, mem_wr=0, mem_addr=base+2*issue_cnt. issue_cnt saturates at 8, after which mem_enable=0.
  - Return phase: each mem_data_valid drives fill_data=mem_rdata, fill_word_idx=ret_cnt, asserts the granted cache's data_valid, and increments ret_cnt.
  - Completion: on the 8th return, done pulses in the same cycle as the last data_valid. The next state is IDLE and the counters clear.
  - Nominal fill length is 12 cycles (8 issue + MEM_LATENCY).
- WRITE_D: lasts one cycle with mem_enable=1, mem_wr=1, mem_addr=dcache_addr, mem_wdata=dcache_wdata, and dcache_done=1. The next state is IDLE.
- Requester contract:
  - Deassert req in the cycle after done.
  - The arbiter always spends at least one cycle in IDLE between transactions, so a stale req is never re-granted.
- mem_data_valid is ignored in IDLE and WRITE_D. Stray returns after reset are dropped.
- Reset mid-fill aborts the transaction immediately: no done pulse, and partial data is already delivered. The cache must re-request.
- The _data_valid/_done outputs of the non-granted side are always 0.
- Address arithmetic is modulo 2^ADDR_W. Base is block-aligned, so no carry escapes the block.

Test Plan:
- I-only fill, icache_addr=0x1236: mem_addr runs 0x1230..0x123E over 8 cycles. With memory returning 0xA000+idx, icache_data_valid occurs 8 times with idx 0..7. icache_done pulses on the 8th return, 12 cycles after grant.
- D write, dcache_we=1, addr=0x0040, wdata=0xBEEF: one cycle of mem_enable=1, mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, with dcache_done in the same cycle. Back in IDLE next cycle.
- Simultaneous I and D fill requests after reset: D is granted first (base of 0x2008 is 0x2000). After dcache_done, one IDLE cycle, then I is granted.
- Back-to-back ties: D and I both held continuously. Grants alternate D, I, D; no requester is granted twice in a row.
- rst pulsed at cycle 5 of a D fill: all outputs go to 0 asynchronously and dcache_done never pulses. Late mem_data_valid pulses are ignored, and a fresh request is granted normally.
- Request arriving during a busy fill: I requests while D fill is active. I waits with icache_grant=0 and is granted in the cycle after IDLE samples it.
